line_drawer_stream: RTL and testbench
=====================================

Name: line_drawer_stream

Overview:
- Parametrised Bresenham line rasteriser; the next generation of the project's line drawer.
- Takes two explicit endpoints per command, latched on a start pulse. Emits one pixel per valid/ready handshake toward the VGA frame-buffer writer.
- Adds a programmable pixel pacing divider, an abort input, a busy flag, a one-cycle done pulse and a pixel counter.
- Sits between the game or animation control FSM and the frame-buffer write port.

Parameters:
COORD_W, 11, width of every coordinate; coordinates are signed two's complement.
PACE_W, 24, width of the pacing counter and of the pace input.
CNT_W, 12, width of pix_count.

Ports:
clk  in  1  system clock, 50 MHz.
reset  in  1  asynchronous reset, active-low (asserted when 0).
start  in  1  command strobe; sampled only in IDLE.
abort  in  1  cancels the line in progress.
x0, y0  in  COORD_W signed  start point; latched on accepted start.
x1, y1  in  COORD_W signed  end point; latched on accepted start.
pace  in  PACE_W  idle cycles inserted after each accepted pixel; latched on start.
pix_valid  out  1  pix_x/pix_y hold a pixel to draw.
pix_ready  in  1  downstream accepts the pixel.
pix_x, pix_y  out  COORD_W signed  current pixel.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse after the final pixel handshake.
pix_count  out  CNT_W  pixels accepted since the last accepted start.

Behaviour:
- Reset (async, low): state=IDLE; pix_valid=0, busy=0, done=0, pix_x=pix_y=0, pix_count=0. All internal registers are cleared.
- States are IDLE, SETUP, DRAW, PACE, DONE.
- IDLE:
  - When start=1, latch x0, y0, x1, y1 and pace, clear pix_count, and go to SETUP.
  - start is ignored in every other state.
- SETUP (1 cycle):
  - dx = |x1-x0|; dy = -|y1-y0|.
  - sx = +1 if x0<x1, else -1; sy = +1 if y0<y1, else -1.
  - err = dx+dy; cur = (x0, y0). Go to DRAW.
  - dx, dy and err are COORD_W+1 bits; e2 = 2*err is COORD_W+2 bits; all signed.
- DRAW:
  - pix_valid=1 with pix_x/pix_y=cur, held stable until pix_ready.
  - On handshake, pix_count increments, saturating at all-ones.
  - If cur==end, go to DONE.
  - Otherwise take one Bresenham step:
    - if e2>=dy: x+=sx and err+=dy.
    - if e2<=dx: y+=sy and err+=dx.
    - If both conditions hold, both updates apply in the same cycle (err+=dx+dy).
  - Then go to PACE if pace!=0, loading the counter with pace-1. Otherwise stay in DRAW, with the next pixel valid on the following cycle.
- PACE: pix_valid=0; the counter decrements each cycle; at 0, go to DRAW.
- DONE: done=1 for exactly one cycle, then go to IDLE. pix_count holds until the next start.
- Pixels per line = max(dx, -dy)+1. A degenerate line (x0==x1 and y0==y1) emits exactly one pixel.
- Latency: start sampled at edge T gives SETUP at T+1 and first pix_valid at T+2. The final handshake at edge N gives done high during cycle N+1.
- Abort:
  - abort=1 in any non-IDLE state moves the block to IDLE on the next edge, with pix_valid=0 and no done pulse.
  - pix_count retains the number of accepted pixels.
  - If abort coincides with the final handshake, abort wins: no done, but the pixel still counts.
  - abort in IDLE has no effect.
- Simultaneous start and abort in IDLE: start is accepted.
- Backpressure: pix_x, pix_y and internal state are frozen while pix_valid=1 and pix_ready=0. No pixel is ever dropped or duplicated.
- Inputs x0..y1 and pace may change freely after the start is accepted without affecting the line in flight.

Test Plan:
- (0,0)->(4,2), pace=0, pix_ready=1 -> pixels (0,0),(1,1),(2,1),(3,2),(4,2) on consecutive cycles; first at T+2; done one cycle after the last; pix_count=5.
- (10,10)->(6,8), pace=0 -> (10,10),(9,9),(8,9),(7,8),(6,8); done pulses once; busy low the cycle after done.
- Vertical (5,5)->(5,8) and degenerate (7,7)->(7,7) -> 4 pixels x=5, y=5..8; then a single pixel (7,7) with pix_count=1.
- (0,0)->(4,2) with pace=3 and pix_ready toggling 1,0,0,1 -> each pixel held until accepted; exactly 3 idle cycles between an accept and the next pix_valid; same 5 pixels in order.
- Abort after 2 accepted pixels of (0,0)->(20,0) -> IDLE next cycle, no done, pix_count=2. A new start then draws normally; start asserted while busy is ignored.
- Reset driven low mid-line (asynchronously, between clock edges) -> outputs zero immediately. After release, a start produces a correct full line.

Source files
------------

// File: rtl/line_drawer_stream_if.sv
// Command/pixel-stream bundle between the control FSM, the line drawer and the
// frame-buffer writer. The slave modport is the drawer's view.
interface line_drawer_stream_if #(
    parameter int COORD_W = 11,
    parameter int PACE_W  = 24,
    parameter int CNT_W   = 12
);
    logic                      start;
    logic                      abort;
    logic signed [COORD_W-1:0] x0;
    logic signed [COORD_W-1:0] y0;
    logic signed [COORD_W-1:0] x1;
    logic signed [COORD_W-1:0] y1;
    logic [PACE_W-1:0]         pace;
    logic                      pix_valid;
    logic                      pix_ready;
    logic signed [COORD_W-1:0] pix_x;
    logic signed [COORD_W-1:0] pix_y;
    logic                      busy;
    logic                      done;
    logic [CNT_W-1:0]          pix_count;

    modport master (
        output start, abort, x0, y0, x1, y1, pace, pix_ready,
        input  pix_valid, pix_x, pix_y, busy, done, pix_count
    );

    modport slave (
        input  start, abort, x0, y0, x1, y1, pace, pix_ready,
        output pix_valid, pix_x, pix_y, busy, done, pix_count
    );
endinterface

// File: rtl/line_drawer_stream.sv
// Bresenham line rasteriser: latches two signed endpoints on start and streams one
// pixel per valid/ready handshake, with optional idle pacing between pixels.
module line_drawer_stream #(
    parameter int COORD_W = 11,
    parameter int PACE_W  = 24,
    parameter int CNT_W   = 12
) (
    input  logic                clk,
    input  logic                reset,
    line_drawer_stream_if.slave bus
);
    localparam int EW  = COORD_W + 1;
    localparam int E2W = COORD_W + 2;
    localparam logic signed [EW-1:0] ZERO_E = '0;

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_DRAW, S_PACE, S_DONE} state_t;

    state_t                    r_state;
    logic signed [COORD_W-1:0] r_x0, r_y0, r_x1, r_y1;
    logic signed [COORD_W-1:0] r_cur_x, r_cur_y;
    logic [PACE_W-1:0]         r_pace, r_pcnt;
    logic signed [EW-1:0]      r_dx, r_dy, r_err;
    logic                      r_sx_neg, r_sy_neg;
    logic                      r_valid, r_busy, r_done;
    logic [CNT_W-1:0]          r_count;

    function automatic logic signed [EW-1:0] abs_e(input logic signed [EW-1:0] v);
        return v[EW-1] ? -v : v;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Endpoint deltas, sign-extended by one bit so |x1-x0| never overflows
    logic signed [EW-1:0] w_ddx, w_ddy, w_adx, w_ady;
    assign w_ddx = {r_x1[COORD_W-1], r_x1} - {r_x0[COORD_W-1], r_x0};
    assign w_ddy = {r_y1[COORD_W-1], r_y1} - {r_y0[COORD_W-1], r_y0};
    assign w_adx = abs_e(w_ddx);
    assign w_ady = abs_e(w_ddy);

    logic signed [E2W-1:0] w_e2, w_dx_w, w_dy_w;
    logic                  w_step_x, w_step_y, w_at_end;
    logic signed [EW-1:0]  w_err_nxt;
    logic signed [COORD_W-1:0] w_nx, w_ny;

    assign w_e2     = {r_err, 1'b0};
    assign w_dx_w   = {r_dx[EW-1], r_dx};
    assign w_dy_w   = {r_dy[EW-1], r_dy};
    assign w_step_x = (w_e2 >= w_dy_w);
    assign w_step_y = (w_e2 <= w_dx_w);
    assign w_err_nxt = r_err + (w_step_x ? r_dy : ZERO_E) + (w_step_y ? r_dx : ZERO_E);
    assign w_nx = !w_step_x ? r_cur_x :
                  (r_sx_neg ? r_cur_x - COORD_W'(1) : r_cur_x + COORD_W'(1));
    assign w_ny = !w_step_y ? r_cur_y :
                  (r_sy_neg ? r_cur_y - COORD_W'(1) : r_cur_y + COORD_W'(1));
    assign w_at_end = (r_cur_x == r_x1) && (r_cur_y == r_y1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_x0     <= '0;
            r_y0     <= '0;
            r_x1     <= '0;
            r_y1     <= '0;
            r_cur_x  <= '0;
            r_cur_y  <= '0;
            r_pace   <= '0;
            r_pcnt   <= '0;
            r_dx     <= '0;
            r_dy     <= '0;
            r_err    <= '0;
            r_sx_neg <= 1'b0;
            r_sy_neg <= 1'b0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_count  <= '0;
        end else begin
            // A handshake counts even when abort lands on the same edge
            if (r_valid && bus.pix_ready)
                r_count <= sat_inc(r_count);

            if (bus.abort && r_state != S_IDLE) begin
                r_state <= S_IDLE;
                r_valid <= 1'b0;
                r_busy  <= 1'b0;
                r_done  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_done <= 1'b0;
                        if (bus.start) begin
                            r_x0    <= bus.x0;
                            r_y0    <= bus.y0;
                            r_x1    <= bus.x1;
                            r_y1    <= bus.y1;
                            r_pace  <= bus.pace;
                            r_count <= '0;
                            r_busy  <= 1'b1;
                            r_state <= S_SETUP;
                        end
                    end
                    S_SETUP: begin
                        r_dx     <= w_adx;
                        r_dy     <= -w_ady;
                        r_err    <= w_adx - w_ady;
                        r_sx_neg <= !(r_x0 < r_x1);
                        r_sy_neg <= !(r_y0 < r_y1);
                        r_cur_x  <= r_x0;
                        r_cur_y  <= r_y0;
                        r_valid  <= 1'b1;
                        r_state  <= S_DRAW;
                    end
                    S_DRAW: begin
                        if (bus.pix_ready) begin
                            if (w_at_end) begin
                                r_valid <= 1'b0;
                                r_done  <= 1'b1;
                                r_state <= S_DONE;
                            end else begin
                                r_cur_x <= w_nx;
                                r_cur_y <= w_ny;
                                r_err   <= w_err_nxt;
                                if (r_pace != '0) begin
                                    r_valid <= 1'b0;
                                    r_pcnt  <= r_pace - PACE_W'(1);
                                    r_state <= S_PACE;
                                end
                            end
                        end
                    end
                    S_PACE: begin
                        if (r_pcnt == '0) begin
                            r_valid <= 1'b1;
                            r_state <= S_DRAW;
                        end else begin
                            r_pcnt <= r_pcnt - PACE_W'(1);
                        end
                    end
                    S_DONE: begin
                        r_done  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.pix_valid = r_valid;
    assign bus.pix_x     = r_cur_x;
    assign bus.pix_y     = r_cur_y;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.pix_count = r_count;
endmodule

// File: tb/tb_line_drawer_stream.sv
// Scoreboard bench for line_drawer_stream: stimulus queues hand-computed pixels,
// a negedge monitor pops and compares them on every handshake.
module tb_line_drawer_stream;
    localparam int COORD_W = 11;
    localparam int PACE_W  = 24;
    localparam int CNT_W   = 12;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    line_drawer_stream_if #(.COORD_W(COORD_W), .PACE_W(PACE_W), .CNT_W(CNT_W)) bus();

    line_drawer_stream #(.COORD_W(COORD_W), .PACE_W(PACE_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        int x;
        int y;
    } pix_t;

    pix_t exp_q[$];
    pix_t mon_e;
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic push(input int x, input int y);
        pix_t p;
        p.x = x;
        p.y = y;
        exp_q.push_back(p);
    endtask

    task automatic push_line_a();
        push(0, 0); push(1, 1); push(2, 1); push(3, 2); push(4, 2);
    endtask

    // Drives start for one edge, then scrambles the command inputs
    task automatic start_line(input int ax0, input int ay0, input int ax1, input int ay1,
                              input int apace);
        tick();
        bus.x0    = COORD_W'(ax0);
        bus.y0    = COORD_W'(ay0);
        bus.x1    = COORD_W'(ax1);
        bus.y1    = COORD_W'(ay1);
        bus.pace  = PACE_W'(apace);
        bus.start = 1'b1;
        neg();
        chk("idle_busy_before_start", int'(bus.busy), 0);
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.x0    = COORD_W'(-300);
        bus.y0    = COORD_W'(123);
        bus.x1    = COORD_W'(77);
        bus.y1    = COORD_W'(-9);
        bus.pace  = PACE_W'(5);
        neg();
        chk("setup_busy", int'(bus.busy), 1);
        chk("setup_valid", int'(bus.pix_valid), 0);
    endtask

    task automatic drain(input int budget, output int ndone);
        int tout;
        ndone = 0;
        tout  = 1;
        for (int i = 0; i < budget; i++) begin
            tick();
            neg();
            if (bus.done) ndone++;
            if (!bus.busy) begin
                tout = 0;
                break;
            end
        end
        chk("drain_timeout", tout, 0);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (reset && bus.pix_valid && bus.pix_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pixel", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("pix_x", int'(bus.pix_x), mon_e.x);
                    chk("pix_y", int'(bus.pix_y), mon_e.y);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        int   nd;
        int   k;
        int   gap;
        int   ngap;
        int   pending;
        int   tout;
        logic [3:0] patv;

        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.x0 = '0; bus.y0 = '0; bus.x1 = '0; bus.y1 = '0;
        bus.pace = '0;
        bus.pix_ready = 1'b1;

        #3;
        chk("rst_valid", int'(bus.pix_valid), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_x", int'(bus.pix_x), 0);
        chk("rst_y", int'(bus.pix_y), 0);
        chk("rst_count", int'(bus.pix_count), 0);
        #9;
        reset = 1'b1;

        // Line A with exact cycle timing
        push_line_a();
        start_line(0, 0, 4, 2, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            neg();
            chk("a_consecutive_valid", int'(bus.pix_valid), 1);
        end
        tick();
        neg();
        chk("a_done_pulse", int'(bus.done), 1);
        chk("a_count", int'(bus.pix_count), 5);
        tick();
        neg();
        chk("a_done_cleared", int'(bus.done), 0);
        chk("a_busy_cleared", int'(bus.busy), 0);
        chk("a_count_hold", int'(bus.pix_count), 5);

        // Reverse direction line
        push(10, 10); push(9, 9); push(8, 9); push(7, 8); push(6, 8);
        start_line(10, 10, 6, 8, 0);
        drain(50, nd);
        chk("b_done_pulses", nd, 1);
        chk("b_count", int'(bus.pix_count), 5);

        // Vertical, then degenerate with abort raised alongside start
        push(5, 5); push(5, 6); push(5, 7); push(5, 8);
        start_line(5, 5, 5, 8, 0);
        drain(50, nd);
        chk("v_done_pulses", nd, 1);
        chk("v_count", int'(bus.pix_count), 4);
        push(7, 7);
        bus.abort = 1'b1;
        start_line(7, 7, 7, 7, 0);
        drain(50, nd);
        chk("dg_done_pulses", nd, 1);
        chk("dg_count", int'(bus.pix_count), 1);

        // Paced line under toggling backpressure
        push_line_a();
        start_line(0, 0, 4, 2, 3);
        patv = 4'b1001;
        k = 0; gap = 0; ngap = 0; pending = 0; nd = 0; tout = 1;
        for (int i = 0; i < 200; i++) begin
            tick();
            bus.pix_ready = patv[3 - (k % 4)];
            k++;
            neg();
            if (pending != 0) begin
                if (bus.pix_valid) begin
                    chk("pace_gap", gap, 3);
                    ngap++;
                    pending = 0;
                end else begin
                    gap++;
                end
            end
            if (bus.pix_valid && bus.pix_ready) begin
                pending = 1;
                gap = 0;
            end
            if (bus.done) nd++;
            if (!bus.busy) begin
                tout = 0;
                break;
            end
        end
        chk("pace_timeout", tout, 0);
        chk("pace_gaps_seen", ngap, 4);
        chk("pace_done_pulses", nd, 1);
        chk("pace_count", int'(bus.pix_count), 5);

        // Abort after two accepted pixels
        bus.pix_ready = 1'b1;
        push(0, 0); push(1, 0);
        start_line(0, 0, 20, 0, 0);
        tick(); neg();
        tick(); neg();
        tick();
        bus.pix_ready = 1'b0;
        bus.abort = 1'b1;
        neg();
        chk("ab_third_valid", int'(bus.pix_valid), 1);
        tick();
        bus.abort = 1'b0;
        neg();
        chk("ab_valid", int'(bus.pix_valid), 0);
        chk("ab_busy", int'(bus.busy), 0);
        chk("ab_done", int'(bus.done), 0);
        chk("ab_count", int'(bus.pix_count), 2);
        tick();
        bus.abort = 1'b1;
        neg();
        chk("ab_no_late_done", int'(bus.done), 0);
        tick();
        bus.abort = 1'b0;
        neg();
        chk("ab_idle_abort_busy", int'(bus.busy), 0);
        chk("ab_idle_abort_count", int'(bus.pix_count), 2);

        // Negative-going line; a start while busy must be ignored
        bus.pix_ready = 1'b1;
        push(0, 0); push(-1, 1); push(-2, 1); push(-3, 2);
        start_line(0, 0, -3, 2, 0);
        tick();
        bus.start = 1'b1;
        bus.x0 = COORD_W'(50); bus.y0 = COORD_W'(50);
        bus.x1 = COORD_W'(60); bus.y1 = COORD_W'(40);
        tick();
        tick();
        bus.start = 1'b0;
        drain(50, nd);
        chk("neg_done_pulses", nd, 1);
        chk("neg_count", int'(bus.pix_count), 4);

        // Asynchronous reset in the middle of a line
        push(0, 0); push(1, 0); push(2, 0);
        start_line(0, 0, 20, 0, 0);
        tick(); neg();
        tick(); neg();
        tick(); neg();
        tick();
        bus.pix_ready = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("ar_valid", int'(bus.pix_valid), 0);
        chk("ar_busy", int'(bus.busy), 0);
        chk("ar_x", int'(bus.pix_x), 0);
        chk("ar_count", int'(bus.pix_count), 0);
        tick();
        tick();
        reset = 1'b1;
        bus.pix_ready = 1'b1;
        push_line_a();
        start_line(0, 0, 4, 2, 0);
        drain(50, nd);
        chk("ar_line_done_pulses", nd, 1);
        chk("ar_line_count", int'(bus.pix_count), 5);

        tick();
        neg();
        chk("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
